// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one data-memory port between the instruction-fetch requester (IF)
//   and the load/store unit (LS). Arbitration is fixed priority LS > IF, but
//   an anti-starvation counter forces an IF grant after MAX_WAIT consecutive
//   IF losses. Each winning command is registered, driven to memory for a
//   single ACCESS cycle, and its response is returned one cycle later through
//   registered RDATA/RVALID outputs.
//
//   Timing: REQ seen in IDLE at cycle t -> ACK and memory access at t+1 ->
//   RVALID/RDATA at t+2. The arbitration at t+2 overlaps the RVALID pulse,
//   so the port sustains one access every two cycles.
//
// Parameters:
//   MAX_WAIT  consecutive IF losses (1..15) before IF is forced to win
//   AW        address width
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   IF_REQ/IF_ADDR        fetch request (word read, FUNC3 forced to 3'b010)
//   IF_ACK                one-cycle pulse: fetch command accepted
//   IF_RDATA/IF_RVALID    fetch response (RDATA holds between pulses)
//   LS_REQ/LS_WE/LS_FUNC3/LS_ADDR/LS_WDATA   load/store request
//   LS_ACK                one-cycle pulse: load/store command accepted
//   LS_RDATA/LS_RVALID    load/store response (RDATA is 0 for stores)
//   LS_ERR                misaligned-access flag, qualified by LS_RVALID
//   MEM_MRD/MEM_MWRT/MEM_FUNC3/MEM_ADDR/MEM_WDATA   memory command
//   MEM_RDATA             combinational memory read data
//   BUSY                  high while in the ACCESS state
//
// Build option:
//   MEMARB_MISALIGN_TRAP_EN  when defined, misaligned LS word/halfword
//   accesses are flagged at arbitration, suppressed at the memory port and
//   answered with LS_ERR=1, LS_RDATA=0. When undefined, LS_ERR is tied 0 and
//   all addresses go to memory unchanged.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    // instruction fetch requester
    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_ACK,
    output logic [31:0]   IF_RDATA,
    output logic          IF_RVALID,
    // load/store requester
    input  logic          LS_REQ,
    input  logic          LS_WE,
    input  logic [2:0]    LS_FUNC3,
    input  logic [AW-1:0] LS_ADDR,
    input  logic [31:0]   LS_WDATA,
    output logic          LS_ACK,
    output logic [31:0]   LS_RDATA,
    output logic          LS_RVALID,
    output logic          LS_ERR,
    // memory port
    output logic          MEM_MRD,
    output logic          MEM_MWRT,
    output logic [2:0]    MEM_FUNC3,
    output logic [AW-1:0] MEM_ADDR,
    output logic [31:0]   MEM_WDATA,
    input  logic [31:0]   MEM_RDATA,
    // status
    output logic          BUSY
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [2:0] FUNC3_LW   = 3'b010;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t          state_reg;
    logic [3:0]      cnt_reg;
    logic [3:0]      cnt_next;

    // Command registers, loaded at arbitration and replayed during ACCESS.
    logic [AW-1:0]   cmd_addr_reg;
    logic [2:0]      cmd_func3_reg;
    logic [31:0]     cmd_wdata_reg;
    logic            cmd_we_reg;
    logic            cmd_is_ls_reg;
    logic            cmd_err_reg;

    // Registered requester-facing outputs.
    logic            if_ack_reg;
    logic            if_rvalid_reg;
    logic [31:0]     if_rdata_reg;
    logic            ls_ack_reg;
    logic            ls_rvalid_reg;
    logic [31:0]     ls_rdata_reg;
`ifdef MEMARB_MISALIGN_TRAP_EN
    logic            ls_err_reg;
`endif

    logic            any_req;
    logic            ls_win;
    logic            ls_misalign;

    // -----------------------------------------------------------------------
    // Arbitration and starvation counter
    // -----------------------------------------------------------------------
    always_comb begin
        any_req = IF_REQ | LS_REQ;
        // LS normally wins; IF takes over once it has lost MAX_WAIT times in
        // a row and is still asking.
        ls_win  = LS_REQ && !(IF_REQ && (cnt_reg == MAX_WAIT_C));

        cnt_next = cnt_reg;
        if (state_reg == IDLE) begin
            if (!IF_REQ) begin
                cnt_next = 4'd0;
            end else if (ls_win) begin
                cnt_next = (cnt_reg >= MAX_WAIT_C) ? MAX_WAIT_C : cnt_reg + 4'd1;
            end else begin
                cnt_next = 4'd0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Misalignment detection on the LS command being arbitrated
    // -----------------------------------------------------------------------
`ifdef MEMARB_MISALIGN_TRAP_EN
    always_comb begin
        ls_misalign = ((LS_FUNC3[1:0] == 2'b10) && (LS_ADDR[1:0] != 2'b00)) ||
                      ((LS_FUNC3[1:0] == 2'b01) && LS_ADDR[0]);
    end
`else
    always_comb begin
        ls_misalign = 1'b0;
    end
`endif

    // -----------------------------------------------------------------------
    // Two-state FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            cmd_addr_reg  <= '0;
            cmd_func3_reg <= 3'b000;
            cmd_wdata_reg <= 32'd0;
            cmd_we_reg    <= 1'b0;
            cmd_is_ls_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
            if_ack_reg    <= 1'b0;
            if_rvalid_reg <= 1'b0;
            if_rdata_reg  <= 32'd0;
            ls_ack_reg    <= 1'b0;
            ls_rvalid_reg <= 1'b0;
            ls_rdata_reg  <= 32'd0;
`ifdef MEMARB_MISALIGN_TRAP_EN
            ls_err_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    // Response pulses from the previous access end here.
                    if_rvalid_reg <= 1'b0;
                    ls_rvalid_reg <= 1'b0;
`ifdef MEMARB_MISALIGN_TRAP_EN
                    ls_err_reg    <= 1'b0;
`endif
                    cnt_reg       <= cnt_next;
                    if (any_req) begin
                        state_reg     <= ACCESS;
                        cmd_is_ls_reg <= ls_win;
                        if (ls_win) begin
                            cmd_addr_reg  <= LS_ADDR;
                            cmd_func3_reg <= LS_FUNC3;
                            cmd_wdata_reg <= LS_WDATA;
                            cmd_we_reg    <= LS_WE;
                            cmd_err_reg   <= ls_misalign;
                            ls_ack_reg    <= 1'b1;
                            if_ack_reg    <= 1'b0;
                        end else begin
                            cmd_addr_reg  <= IF_ADDR;
                            cmd_func3_reg <= FUNC3_LW;
                            cmd_wdata_reg <= 32'd0;
                            cmd_we_reg    <= 1'b0;
                            cmd_err_reg   <= 1'b0;
                            ls_ack_reg    <= 1'b0;
                            if_ack_reg    <= 1'b1;
                        end
                    end else begin
                        if_ack_reg <= 1'b0;
                        ls_ack_reg <= 1'b0;
                    end
                end

                ACCESS: begin
                    // The access always completes in one cycle; the response
                    // is captured on this closing edge.
                    state_reg  <= IDLE;
                    if_ack_reg <= 1'b0;
                    ls_ack_reg <= 1'b0;
                    if (cmd_is_ls_reg) begin
                        ls_rvalid_reg <= 1'b1;
                        if_rvalid_reg <= 1'b0;
                        // Stores and trapped accesses never return memory data.
                        ls_rdata_reg  <= (cmd_we_reg || cmd_err_reg) ? 32'd0 : MEM_RDATA;
`ifdef MEMARB_MISALIGN_TRAP_EN
                        ls_err_reg    <= cmd_err_reg;
`endif
                    end else begin
                        if_rvalid_reg <= 1'b1;
                        ls_rvalid_reg <= 1'b0;
                        if_rdata_reg  <= MEM_RDATA;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output drive
    // -----------------------------------------------------------------------
    logic busy_w;
    assign busy_w = (state_reg == ACCESS);

    // Read/write strobes are gated by RESET directly so an access interrupted
    // by reset never reaches memory, even in the cycle reset is first seen.
    assign MEM_MRD   = busy_w && !cmd_we_reg && !cmd_err_reg && !RESET;
    assign MEM_MWRT  = busy_w &&  cmd_we_reg && !cmd_err_reg && !RESET;
    assign MEM_FUNC3 = busy_w ? cmd_func3_reg : 3'b000;
    assign MEM_ADDR  = busy_w ? cmd_addr_reg  : '0;
    assign MEM_WDATA = busy_w ? cmd_wdata_reg : 32'd0;
    assign BUSY      = busy_w;

    assign IF_ACK    = if_ack_reg;
    assign IF_RVALID = if_rvalid_reg;
    assign IF_RDATA  = if_rdata_reg;
    assign LS_ACK    = ls_ack_reg;
    assign LS_RVALID = ls_rvalid_reg;
    assign LS_RDATA  = ls_rdata_reg;
`ifdef MEMARB_MISALIGN_TRAP_EN
    assign LS_ERR    = ls_err_reg;
`else
    assign LS_ERR    = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port (MRd/MWrt/FUNC3/ADDR/W_DATA/R_DATA) between two requesters: instruction fetch (IF) and load/store unit (LS).
- Fixed priority LS > IF, with an anti-starvation counter that forces an IF grant after MAX_WAIT consecutive losses.
- Registers each winning command, issues it to memory for one cycle, then returns a registered response. Sits between core pipeline and memory.

Parameters:
- MAX_WAIT, 4, consecutive IF losses (1..15) before IF is forced to win the next arbitration.
- AW, 32, address width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous reset, active-high.
- IF_REQ  in  1  fetch request; held high until IF_ACK.
- IF_ADDR  in  AW  fetch byte address; word read, FUNC3 forced 3'b010.
- IF_ACK  out  1  one-cycle pulse: IF command accepted.
- IF_RDATA  out  32  fetch data, valid with IF_RVALID.
- IF_RVALID  out  1  one-cycle pulse: IF_RDATA valid.
- LS_REQ  in  1  load/store request; held until LS_ACK.
- LS_WE  in  1  1 = store, 0 = load.
- LS_FUNC3  in  3  RISC-V load/store funct3, passed to memory.
- LS_ADDR  in  AW  byte address.
- LS_WDATA  in  32  store data.
- LS_ACK  out  1  one-cycle pulse: LS command accepted.
- LS_RDATA  out  32  load data (0 for stores).
- LS_RVALID  out  1  one-cycle pulse: LS response (loads and stores).
- LS_ERR  out  1  misaligned-access flag, qualified by LS_RVALID.
- MEM_MRD  out  1  memory read enable.
- MEM_MWRT  out  1  memory write enable.
- MEM_FUNC3  out  3  memory funct3.
- MEM_ADDR  out  AW  memory byte address.
- MEM_WDATA  out  32  memory write data.
- MEM_RDATA  in  32  memory combinational read data.
- BUSY  out  1  high in ACCESS state.

Behaviour:
- Reset, synchronous, active-high: state IDLE, wait counter 0, all outputs 0.
- Reset asserted in ACCESS: MEM_MRD and MEM_MWRT are gated low combinationally by RESET in that same cycle. The in-flight transaction is dropped and no RVALID is produced.
- FSM has two states, IDLE and ACCESS.
- IDLE, no request: stay in IDLE.
- IDLE, any REQ: pick a winner, latch its addr/func3/wdata/we and the winner id into command registers, go to ACCESS. The winner's ACK is registered, so it is high for exactly the ACCESS cycle.
- ACCESS:
  - MEM_* are driven from the command registers.
  - MEM_MRD = !we, MEM_MWRT = we.
  - At the closing edge, MEM_RDATA is captured into the winner's RDATA register (LS store: RDATA = 0).
  - Winner's RVALID is pulsed the next cycle.
  - Always return to IDLE.
- Latency: REQ seen in IDLE at cycle t -> ACK at t+1 (ACCESS) -> RVALID/RDATA at t+2. Peak throughput is one access per 2 cycles. Arbitration at t+2 overlaps the RVALID pulse.
- Requesters drop REQ (or present a new command) on the edge after ACK. A REQ still high in IDLE counts as a new request.
- Arbitration rule:
  - Winner is LS if LS_REQ && !(IF_REQ && cnt == MAX_WAIT); otherwise IF.
- Counter update:
  - cnt increments when IF_REQ and LS wins.
  - cnt clears when IF wins or when IF_REQ is low in IDLE.
  - cnt saturates at MAX_WAIT.
- RDATA outputs hold their last value between RVALID pulses.
- MEM_* outputs are 0 in IDLE.

Optional Feature:
- MEMARB_MISALIGN_TRAP_EN.
- Defined: at arbitration, an LS command is flagged misaligned when:
  - func3[1:0] == 2'b10 and addr[1:0] != 0, or
  - func3[1:0] == 2'b01 and addr[0] != 0.
- Defined, misaligned command: still goes through ACCESS, LS_ACK and BUSY behave normally, but MEM_MRD and MEM_MWRT stay 0. At t+2: LS_RVALID = 1, LS_ERR = 1, LS_RDATA = 0.
- Not defined: no check; LS_ERR is tied 0; misaligned addresses go to memory unchanged.

Test Plan:
- Reset, then IF_REQ with IF_ADDR=0x100 and MEM_RDATA=0xDEADBEEF -> IF_ACK at t+1 with MEM_MRD=1, MEM_ADDR=0x100, MEM_FUNC3=3'b010; IF_RVALID=1 and IF_RDATA=0xDEADBEEF at t+2.
- LS store: LS_WE=1, LS_FUNC3=3'b000, LS_ADDR=0x203, LS_WDATA=0xAB -> MEM_MWRT=1 only in the ACCESS cycle; LS_RVALID at t+2 with LS_RDATA=0.
- IF_REQ and LS_REQ held continuously, MAX_WAIT=4, each requester re-requests after its ACK -> grant order LS,LS,LS,LS,IF, repeating; counter returns to 0 after each IF grant.
- RESET pulsed during an LS-store ACCESS cycle -> MEM_MWRT=0 that cycle, no LS_RVALID, state IDLE, all outputs 0 on the next cycle.
- With MEMARB_MISALIGN_TRAP_EN defined: LW with LS_ADDR=0x102 -> MEM_MRD=0 throughout; LS_RVALID=1, LS_ERR=1, LS_RDATA=0 at t+2.
- Same LW with the macro not defined -> MEM_MRD=1, MEM_ADDR=0x102, LS_ERR=0.
